// File: rtl/riscv_mc_pkg.sv
// Shared definitions for the multicycle RV32 core:
// opcode/funct constants, FSM states, ALU ops.
package riscv_mc_pkg;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_AND = 3'b111;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_W   = 3'b010;
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_SUB  = 7'b0100000;

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      EXECUTE,
      MEM,
      WB,
      HALT
   } state_e;

   typedef enum logic [1:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR
   } alu_op_e;

   typedef enum logic [2:0] {
      CL_ALU,
      CL_LW,
      CL_SW,
      CL_BEQ,
      CL_BNE
   } cls_e;

   function automatic logic [31:0] imm_i(input logic [31:0] ir);
      return {{20{ir[31]}}, ir[31:20]};
   endfunction

   function automatic logic [31:0] imm_s(input logic [31:0] ir);
      return {{20{ir[31]}}, ir[31:25], ir[11:7]};
   endfunction

   function automatic logic [31:0] imm_b(input logic [31:0] ir);
      return {{19{ir[31]}}, ir[31], ir[7],
              ir[30:25], ir[11:8], 1'b0};
   endfunction

endpackage

// File: rtl/mc_alu.sv
// ALU for the multicycle core: add/sub/and/or
// plus an operand equality flag for branches.
module mc_alu
   import riscv_mc_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  alu_op_e     op,
   output logic [31:0] result,
   output logic        eq
);

   // Select the arithmetic/logic result
   always_comb begin
      result = a + b;
      unique case (op)
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
      endcase
   end

   assign eq = (a == b);

endmodule

// File: rtl/multicycle_core.sv
// Multicycle RV32I subset core with a single shared
// memory port and an internal register file.
module multicycle_core
   import riscv_mc_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          NREG     = 32
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        retire,
   output logic        trap,
   output logic [31:0] pc_out,
   input  logic [4:0]  dbg_rf_addr,
   output logic [31:0] dbg_rf_data
);

   localparam int AW = $clog2(NREG);

   state_e      state_q, state_d;
   cls_e        cls_q, cls_d;
   alu_op_e     op_q, op_d;
   logic        bsel_q, bsel_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] imm_q, imm_d;
   logic [31:0] alu_q, alu_d;
   logic [31:0] mdr_q, mdr_d;

   logic [31:0] rf_q [NREG];
   logic        rf_we;
   logic [31:0] rf_wdata;

   logic [6:0]  opc, f7;
   logic [2:0]  f3;
   logic [4:0]  rs1, rs2, rd;
   cls_e        dec_cls;
   alu_op_e     dec_op;
   logic        dec_bsel, dec_ill;
   logic        use_rs2, use_rd;
   logic [31:0] dec_imm;

   logic [31:0] alu_b, alu_res;
   logic        alu_eq, taken;
   logic [31:0] pc_inc, br_tgt, br_next;

   function automatic logic bad_idx(input logic [4:0] idx);
      return {27'd0, idx} >= NREG;
   endfunction

   function automatic logic [31:0] rf_rd(input logic [4:0] idx);
      if (idx == 5'd0 || bad_idx(idx))
         return '0;
      return rf_q[idx[AW-1:0]];
   endfunction

   assign opc = ir_q[6:0];
   assign f3  = ir_q[14:12];
   assign f7  = ir_q[31:25];
   assign rs1 = ir_q[19:15];
   assign rs2 = ir_q[24:20];
   assign rd  = ir_q[11:7];

   assign dbg_rf_data = rf_rd(dbg_rf_addr);
   assign pc_out      = pc_q;
   assign trap        = (state_q == HALT);

   assign alu_b   = bsel_q ? imm_q : b_q;
   assign pc_inc  = pc_q + 32'd4;
   assign br_tgt  = pc_q + imm_q;
   assign taken   = (cls_q == CL_BEQ) ? alu_eq : !alu_eq;
   assign br_next = taken ? br_tgt : pc_inc;

   mc_alu u_alu (
      .a      (a_q),
      .b      (alu_b),
      .op     (op_q),
      .result (alu_res),
      .eq     (alu_eq)
   );

   // Decode the latched instruction word
   always_comb begin
      dec_cls  = CL_ALU;
      dec_op   = ALU_ADD;
      dec_bsel = 1'b0;
      dec_imm  = imm_i(ir_q);
      dec_ill  = 1'b0;
      use_rs2  = 1'b0;
      use_rd   = 1'b0;
      unique case (opc)
         OP_R: begin
            use_rs2 = 1'b1;
            use_rd  = 1'b1;
            unique case ({f7, f3})
               {F7_BASE, F3_ADD}: dec_op = ALU_ADD;
               {F7_SUB,  F3_ADD}: dec_op = ALU_SUB;
               {F7_BASE, F3_AND}: dec_op = ALU_AND;
               {F7_BASE, F3_OR}:  dec_op = ALU_OR;
               default:           dec_ill = 1'b1;
            endcase
         end
         OP_I: begin
            use_rd   = 1'b1;
            dec_bsel = 1'b1;
            dec_ill  = (f3 != F3_ADD);
         end
         OP_LD: begin
            use_rd   = 1'b1;
            dec_bsel = 1'b1;
            dec_cls  = CL_LW;
            dec_ill  = (f3 != F3_W);
         end
         OP_ST: begin
            use_rs2  = 1'b1;
            dec_bsel = 1'b1;
            dec_cls  = CL_SW;
            dec_imm  = imm_s(ir_q);
            dec_ill  = (f3 != F3_W);
         end
         OP_BR: begin
            use_rs2 = 1'b1;
            dec_imm = imm_b(ir_q);
            if (f3 == F3_BEQ)
               dec_cls = CL_BEQ;
            else if (f3 == F3_BNE)
               dec_cls = CL_BNE;
            else
               dec_ill = 1'b1;
         end
         default: dec_ill = 1'b1;
      endcase
      if (bad_idx(rs1) ||
          (use_rs2 && bad_idx(rs2)) ||
          (use_rd && bad_idx(rd)))
         dec_ill = 1'b1;
   end

   // Next-state, datapath latches and bus outputs
   always_comb begin
      state_d   = state_q;
      cls_d     = cls_q;
      op_d      = op_q;
      bsel_d    = bsel_q;
      rd_d      = rd_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      a_d       = a_q;
      b_d       = b_q;
      imm_d     = imm_q;
      alu_d     = alu_q;
      mdr_d     = mdr_q;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      retire    = 1'b0;
      rf_we     = 1'b0;
      rf_wdata  = '0;
      unique case (state_q)
         FETCH: begin
            mem_req  = 1'b1;
            mem_addr = pc_q;
            if (mem_ready) begin
               ir_d    = mem_rdata;
               state_d = DECODE;
            end
         end
         DECODE: begin
            a_d     = rf_rd(rs1);
            b_d     = rf_rd(rs2);
            imm_d   = dec_imm;
            cls_d   = dec_cls;
            op_d    = dec_op;
            bsel_d  = dec_bsel;
            rd_d    = rd;
            state_d = dec_ill ? HALT : EXECUTE;
         end
         EXECUTE: begin
            alu_d = alu_res;
            unique case (cls_q)
               CL_ALU: state_d = WB;
               CL_LW, CL_SW: begin
                  if (alu_res[1:0] != 2'b00)
                     state_d = HALT;
                  else
                     state_d = MEM;
               end
               default: begin
                  if (br_next[1:0] != 2'b00) begin
                     state_d = HALT;
                  end else begin
                     pc_d    = br_next;
                     retire  = 1'b1;
                     state_d = FETCH;
                  end
               end
            endcase
         end
         MEM: begin
            mem_req  = 1'b1;
            mem_addr = alu_q;
            if (cls_q == CL_SW) begin
               mem_we    = 1'b1;
               mem_wdata = b_q;
            end
            if (mem_ready) begin
               if (cls_q == CL_SW) begin
                  pc_d    = pc_inc;
                  retire  = 1'b1;
                  state_d = FETCH;
               end else begin
                  mdr_d   = mem_rdata;
                  state_d = WB;
               end
            end
         end
         WB: begin
            rf_we    = (rd_q != 5'd0);
            rf_wdata = (cls_q == CL_LW) ? mdr_q : alu_q;
            pc_d     = pc_inc;
            retire   = 1'b1;
            state_d  = FETCH;
         end
         HALT: state_d = HALT;
         default: state_d = HALT;
      endcase
      if (reset) begin
         mem_req = 1'b0;
         retire  = 1'b0;
         rf_we   = 1'b0;
      end
   end

   // State, datapath and register file update
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
         cls_q   <= CL_ALU;
         op_q    <= ALU_ADD;
         bsel_q  <= 1'b0;
         rd_q    <= '0;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         imm_q   <= '0;
         alu_q   <= '0;
         mdr_q   <= '0;
         for (int i = 0; i < NREG; i++)
            rf_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         op_q    <= op_d;
         bsel_q  <= bsel_d;
         rd_q    <= rd_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
         imm_q   <= imm_d;
         alu_q   <= alu_d;
         mdr_q   <= mdr_d;
         if (rf_we)
            rf_q[rd_q[AW-1:0]] <= rf_wdata;
      end
   end

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core with a word
// memory model whose data region can insert wait states.
module tb_multicycle_core;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_req, mem_we, mem_ready;
   logic        retire, trap;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [31:0] pc_out, dbg_rf_data;
   logic [4:0]  dbg_rf_addr = 5'd0;

   int compared = 0;
   int mismatched = 0;
   int lat = 0;
   int wait_cnt = 0;
   int cyc = 0;

   logic [31:0] mem [256];
   int          ret_cyc [$];
   logic [31:0] hs_addr [$];
   logic        hs_we [$];

   logic        prev_pend = 1'b0;
   logic        prev_we = 1'b0;
   logic [31:0] prev_addr = '0;
   logic [31:0] prev_wdata = '0;

   always #5 clk = ~clk;

   multicycle_core #(
      .RESET_PC (32'h0000_0000),
      .NREG     (32)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_ready   (mem_ready),
      .mem_rdata   (mem_rdata),
      .retire      (retire),
      .trap        (trap),
      .pc_out      (pc_out),
      .dbg_rf_addr (dbg_rf_addr),
      .dbg_rf_data (dbg_rf_data)
   );

   // fetch region (< 0x40) is zero-wait, data region waits lat cycles
   assign mem_ready = (mem_addr < 32'h40) ? 1'b1 : (wait_cnt >= lat);
   assign mem_rdata = mem[mem_addr[9:2]];

   always @(posedge clk) begin
      if (!mem_req || mem_ready)
         wait_cnt <= 0;
      else
         wait_cnt <= wait_cnt + 1;
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag,
                       input logic obs,
                       input logic exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // bus monitor: log handshakes/retires, apply stores, check stability
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (reset) begin
         prev_pend = 1'b0;
      end else begin
         if (retire)
            ret_cyc.push_back(cyc);
         if (prev_pend) begin
            chk1("stable_req", mem_req, 1'b1);
            chk1("stable_we", mem_we, prev_we);
            chk("stable_addr", mem_addr, prev_addr);
            chk("stable_wdata", mem_wdata, prev_wdata);
         end
         if (mem_req && mem_ready) begin
            hs_addr.push_back(mem_addr);
            hs_we.push_back(mem_we);
            if (mem_we)
               mem[mem_addr[9:2]] = mem_wdata;
         end
         prev_pend  = mem_req && !mem_ready;
         prev_we    = mem_we;
         prev_addr  = mem_addr;
         prev_wdata = mem_wdata;
      end
   end

   function automatic logic [31:0] r_t(
      input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3,
      input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] i_t(
      input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd,
      input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] s_t(
      input logic [11:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] b_t(
      input logic [12:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3,
              imm[4:1], imm[11], 7'b1100011};
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rd_reg(input logic [4:0] idx,
                         input logic [31:0] exp,
                         input string tag);
      dbg_rf_addr = idx;
      #1;
      chk(tag, dbg_rf_data, exp);
   endtask

   task automatic wait_trap(input int budget);
      for (int i = 0; i < budget && trap !== 1'b1; i++)
         step(1);
   endtask

   localparam logic [6:0] OPI = 7'b0010011;
   localparam logic [6:0] OPL = 7'b0000011;

   logic [31:0] exp_hs [17];
   int          exp_gap [6];

   initial begin
      exp_hs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10,
                 32'h18, 32'h1C, 32'h20, 32'h24, 32'h28,
                 32'h80, 32'h2C, 32'h40, 32'h30, 32'h40,
                 32'h34, 32'h38};
      exp_gap = '{4, 4, 4, 3, 3, 4};

      for (int i = 0; i < 256; i++)
         mem[i] = 32'h0000_007F;
      mem[0]  = i_t(12'd5, 5'd0, 3'b000, 5'd1, OPI);
      mem[1]  = i_t(12'd7, 5'd0, 3'b000, 5'd2, OPI);
      mem[2]  = r_t(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
      mem[3]  = r_t(7'h20, 5'd1, 5'd2, 3'b000, 5'd4);
      mem[4]  = b_t(13'd8, 5'd1, 5'd1, 3'b000);
      mem[6]  = b_t(13'd8, 5'd1, 5'd1, 3'b001);
      mem[7]  = i_t(12'd9, 5'd0, 3'b000, 5'd0, OPI);
      mem[8]  = r_t(7'h00, 5'd2, 5'd1, 3'b111, 5'd6);
      mem[9]  = r_t(7'h00, 5'd2, 5'd1, 3'b110, 5'd7);
      mem[10] = i_t(12'h080, 5'd0, 3'b010, 5'd8, OPL);
      mem[11] = s_t(12'h040, 5'd8, 5'd0);
      mem[12] = i_t(12'h040, 5'd0, 3'b010, 5'd5, OPL);
      mem[13] = r_t(7'h20, 5'd1, 5'd0, 3'b000, 5'd9);
      mem[32] = 32'hDEAD_BEEF;
      lat = 3;

      // reset state
      reset = 1'b1;
      step(2);
      chk1("rst_mem_req", mem_req, 1'b0);
      chk1("rst_retire", retire, 1'b0);
      chk1("rst_trap", trap, 1'b0);
      chk("rst_pc", pc_out, 32'h0);
      rd_reg(5'd1, 32'h0, "rst_x1");

      // program 1: ALU, branches, x0 write, lw/sw with waits, illegal
      reset = 1'b0;
      wait_trap(600);
      chk1("p1_trap", trap, 1'b1);
      chk("p1_pc", pc_out, 32'h38);
      rd_reg(5'd0, 32'h0, "x0");
      rd_reg(5'd1, 32'd5, "x1");
      rd_reg(5'd2, 32'd7, "x2");
      rd_reg(5'd3, 32'd12, "x3_add");
      rd_reg(5'd4, 32'd2, "x4_sub");
      rd_reg(5'd6, 32'd5, "x6_and");
      rd_reg(5'd7, 32'd7, "x7_or");
      rd_reg(5'd8, 32'hDEAD_BEEF, "x8_lw");
      rd_reg(5'd5, 32'hDEAD_BEEF, "x5_lw");
      rd_reg(5'd9, 32'hFFFF_FFFB, "x9_wrap");
      chk("mem_0x40", mem[16], 32'hDEAD_BEEF);
      chk("retire_cnt", 32'(ret_cyc.size()), 32'd13);
      for (int i = 0; i < 6; i++)
         chk($sformatf("retire_gap%0d", i),
             32'(ret_cyc[i+1] - ret_cyc[i]), 32'(exp_gap[i]));
      chk("hs_cnt", 32'(hs_addr.size()), 32'd17);
      for (int i = 0; i < 17 && i < hs_addr.size(); i++) begin
         chk($sformatf("hs_addr%0d", i), hs_addr[i], exp_hs[i]);
         chk1($sformatf("hs_we%0d", i), hs_we[i], (i == 12));
      end
      for (int i = 0; i < 4; i++) begin
         step(1);
         chk1("halt_req", mem_req, 1'b0);
         chk1("halt_trap", trap, 1'b1);
         chk1("halt_retire", retire, 1'b0);
         chk("halt_pc", pc_out, 32'h38);
      end
      chk("halt_retire_cnt", 32'(ret_cyc.size()), 32'd13);

      // program 2: misaligned lw traps without writing rd
      reset = 1'b1;
      step(2);
      chk1("rst2_trap", trap, 1'b0);
      rd_reg(5'd3, 32'h0, "rst2_x3");
      mem[0] = i_t(12'd3, 5'd0, 3'b000, 5'd1, OPI);
      mem[1] = i_t(12'd2, 5'd0, 3'b010, 5'd1, OPL);
      ret_cyc.delete();
      reset = 1'b0;
      wait_trap(100);
      chk1("p2_trap", trap, 1'b1);
      chk("p2_pc", pc_out, 32'h04);
      rd_reg(5'd1, 32'd3, "p2_x1");
      chk("p2_retire_cnt", 32'(ret_cyc.size()), 32'd1);
      step(3);
      chk1("p2_halt_req", mem_req, 1'b0);

      // program 3: reset during a pending data request
      reset = 1'b1;
      mem[0] = i_t(12'h080, 5'd0, 3'b010, 5'd1, OPL);
      lat = 10;
      step(2);
      ret_cyc.delete();
      reset = 1'b0;
      for (int i = 0; i < 50 &&
           !(mem_req === 1'b1 && mem_addr === 32'h80); i++)
         step(1);
      chk1("p3_memreq", mem_req, 1'b1);
      chk("p3_memaddr", mem_addr, 32'h80);
      step(2);
      reset = 1'b1;
      #1;
      chk1("p3_rst_req0", mem_req, 1'b0);
      step(1);
      chk1("p3_rst_req1", mem_req, 1'b0);
      chk("p3_rst_pc", pc_out, 32'h0);
      chk1("p3_rst_trap", trap, 1'b0);
      reset = 1'b0;
      #1;
      chk1("p3_fetch_req", mem_req, 1'b1);
      chk1("p3_fetch_we", mem_we, 1'b0);
      chk("p3_fetch_addr", mem_addr, 32'h0);
      chk("p3_retire_cnt", 32'(ret_cyc.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule

// File: doc/multicycle_core.md
MULTICYCLE_CORE -- requirements
Module: multicycle_core

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, byte address of the first fetch after reset; SHALL be word-aligned.
REQ-002 Parameter NREG, 32, number of architectural registers; SHALL be 16 or 32 (RV32E/RV32I register count).
REQ-003 clk  in  1  sole clock; all state SHALL change on rising edge only.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 mem_req  out  1  memory request valid (shared fetch/data port).
REQ-006 mem_we  out  1  1=store, 0=read.
REQ-007 mem_addr  out  32  byte address, word-aligned.
REQ-008 mem_wdata  out  32  store data.
REQ-009 mem_ready  in  1  memory accepts/completes the request this cycle.
REQ-010 mem_rdata  in  32  read data, valid in the cycle mem_req&mem_ready&!mem_we.
REQ-011 retire  out  1  one-cycle pulse per completed instruction.
REQ-012 trap  out  1  sticky: core halted on illegal/misaligned access.
REQ-013 pc_out  out  32  address of the instruction in progress.
REQ-014 dbg_rf_addr  in  5  debug register-file read index; dbg_rf_data  out  32  combinational read value.

Function
REQ-015 Supported instructions SHALL be add, sub, and, or, addi, lw, sw, beq, bne; any other opcode/funct combination is illegal.
REQ-016 FSM states SHALL be FETCH, DECODE, EXECUTE, MEM, WB, HALT.
REQ-017 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on mem_ready latch IR <- mem_rdata, go to DECODE; else stay.
REQ-018 DECODE: latch A<-rs1, B<-rs2, sign-extended immediate (I/S/B formats); illegal -> HALT.
REQ-019 EXECUTE: ALU op; R-type/addi -> WB; lw/sw -> MEM, or HALT if address[1:0]!=0; beq/bne -> FETCH, with PC<-PC+imm if taken, else PC+4.
REQ-020 MEM: mem_req=1, mem_addr=ALU result, mem_we=1 for sw (mem_wdata=B); hold until mem_ready; lw -> WB with data latched; sw -> FETCH with PC+4.
REQ-021 WB: write rd (ALU result or load data), PC<-PC+4, go to FETCH.
REQ-022 retire SHALL pulse in the cycle leaving WB, leaving EXECUTE for branches, or leaving MEM for sw.
REQ-023 With zero-wait memory, cycle counts SHALL be: branch 3, sw 4, R-type/addi 4, lw 5.
REQ-024 While mem_req=1, mem_addr, mem_we and mem_wdata SHALL stay stable until mem_ready; mem_ready with mem_req=0 SHALL be ignored.
REQ-025 Register x0 SHALL always read 0; writes to x0 SHALL be discarded; rd/rs indices >= NREG SHALL be illegal.
REQ-026 Arithmetic SHALL be 32-bit modulo 2^32; overflow ignored; branch target wraps modulo 2^32.
REQ-027 HALT: mem_req=0, trap=1, retire=0, PC frozen; only reset exits.
REQ-028 The faulting instruction SHALL not retire and SHALL not write any register or memory.

Reset
REQ-029 In a reset cycle: state<-FETCH, PC<-RESET_PC, trap<-0, retire<-0, mem_req SHALL be 0 in that cycle, all registers <- 0.
REQ-030 Reset SHALL override any state, including a pending memory request; the first request after reset SHALL be a fetch from RESET_PC.

Structure
REQ-031 Shared package riscv_mc_pkg SHALL hold opcode/funct constants, the FSM state enum, and the ALU-op enum.
REQ-032 A sub-module mc_alu (A, B, op -> result, eq) SHALL implement ADD/SUB/AND/OR and equality.
REQ-033 The register file SHALL be internal, with 2 read ports, 1 write port, and the debug read port.

Verification
REQ-034 Zero-wait memory: addi x1,x0,5; addi x2,x0,7; add x3,x1,x2 -> x3=12, retire pulses 4 cycles apart.
REQ-035 Store 0xDEADBEEF with sw to 0x40, then lw x5,0x40(x0), with mem_ready delayed 3 cycles -> addr/we/wdata stable while waiting, x5=0xDEADBEEF.
REQ-036 beq x1,x1,+8 at PC 0x10 -> next fetch 0x18; bne x1,x1,+8 at 0x18 -> next fetch 0x1C.
REQ-037 addi x0,x0,9 -> dbg read of x0 = 0; opcode 0x7F or lw at address 0x2 -> trap=1, mem_req=0 permanently, no retire.
REQ-038 Reset asserted in MEM with mem_req=1 -> next cycle mem_req=0, pc_out=RESET_PC; following cycle fetches RESET_PC.
